mix_columns_ctrl: RTL and testbench

Sequencing controller for the AES MixColumns step. It accepts one 128-bit state over a valid/ready handshake and drives a shared single-column GF(2^8) mixing unit over the four columns, COLS_PER_CYCLE columns per cycle. It presents the mixed state over a second valid/ready handshake. It sits between ShiftRows and AddRoundKey in the round pipeline, and supports a final-round bypass, since AES omits MixColumns in the last round.

---
 rtl/aes_pkg.sv | 18 +
 rtl/mix_single_column.sv | 24 ++
 rtl/mix_columns_ctrl.sv | 104 ++++++++++
 tb/tb_mix_columns_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte/column/state types and GF(2^8) helpers used by the
// MixColumns sequencing controller.
package aes_pkg;

   typedef logic [7:0] byte_t;
   // Index 3 holds row 0 so the packed layout matches FIPS-197 byte order.
   typedef byte_t [3:0] col_t;
   typedef col_t  [3:0] state_t;

   localparam byte_t GF_POLY_LOW = 8'h1B;

   typedef enum logic [1:0] {IDLE, MIX, DONE} ctrl_state_e;

   function automatic byte_t xtime(input byte_t x);
      return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY_LOW : 8'h00);
   endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns transform of one 4-byte AES column.
module mix_single_column
   import aes_pkg::*;
(
   input  logic [31:0] i_col,
   output logic [31:0] o_col
);

   col_t  w_col;
   byte_t w_a0, w_a1, w_a2, w_a3;

   assign w_col = i_col;
   assign w_a0  = w_col[3];
   assign w_a1  = w_col[2];
   assign w_a2  = w_col[1];
   assign w_a3  = w_col[0];

   // 3x = xtime(x) ^ x, folded into each row.
   assign o_col[31:24] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
   assign o_col[23:16] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
   assign o_col[15:8]  = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
   assign o_col[7:0]   = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);

endmodule

// File: rtl/mix_columns_ctrl.sv
// Sequences one AES state through a shared column mixer, COLS_PER_CYCLE
// columns per clock, with valid/ready on both sides and a final-round bypass.
module mix_columns_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [127:0] i_in_data,
   input  logic         i_in_bypass,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [127:0] o_out_data,
   output logic         o_busy
);

   localparam int unsigned MIX_CYCLES = 4 / COLS_PER_CYCLE;
   localparam logic [1:0]  COL_STEP   = 2'(COLS_PER_CYCLE);
   localparam logic [1:0]  LAST_COL   = 2'((MIX_CYCLES - 1) * COLS_PER_CYCLE);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("mix_columns_ctrl: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   ctrl_state_e r_state;
   logic [1:0]  r_col;
   logic        r_out_valid;
   logic        r_armed;
   state_t      r_work;
   state_t      w_work_mixed;

   logic [COLS_PER_CYCLE-1:0][1:0]  w_slot;
   logic [COLS_PER_CYCLE-1:0][31:0] w_mixed;

   // Column c lives at r_work[3-c]; for a 2-bit index, 3-c == ~c.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
      assign w_slot[g] = ~(r_col + 2'(g));
      mix_single_column u_mix (
         .i_col (r_work[w_slot[g]]),
         .o_col (w_mixed[g])
      );
   end

   always_comb begin
      w_work_mixed = r_work;
      for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
         w_work_mixed[w_slot[g]] = w_mixed[g];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_col       <= '0;
         r_out_valid <= 1'b0;
         r_armed     <= 1'b0;
         r_work      <= '0;
      end else begin
         // Holds in_ready low until the first edge after reset release.
         r_armed <= 1'b1;
         unique case (r_state)
            IDLE: begin
               r_col <= '0;
               if (i_in_valid && o_in_ready) begin
                  r_work <= i_in_data;
                  if (i_in_bypass) begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= MIX;
                  end
               end
            end
            MIX: begin
               r_work <= w_work_mixed;
               r_col  <= r_col + COL_STEP;
               if (r_col == LAST_COL) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (i_out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_armed && (r_state == IDLE);
   assign o_busy      = (r_state != IDLE);
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_work;

endmodule

// File: tb/tb_mix_columns_ctrl.sv
// Self-checking bench for mix_columns_ctrl: vector table, hand-written
// backpressure/reset sequences, a parameter sweep and randomized traffic.
module tb_mix_columns_ctrl;

   localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
   localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
   localparam logic [127:0] C6_IN    = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_bypass, out_ready;
   logic [127:0] in_data;
   logic         rdy1, ov1, busy1;
   logic [127:0] od1;
   logic         sw_valid, sw_ready;
   logic         rdy2, ov2, busy2, rdy4, ov4, busy4;
   logic [127:0] od2, od4;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mix_columns_ctrl #(.COLS_PER_CYCLE(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy1),
      .i_in_data(in_data), .i_in_bypass(in_bypass), .o_out_valid(ov1),
      .i_out_ready(out_ready), .o_out_data(od1), .o_busy(busy1)
   );
   mix_columns_ctrl #(.COLS_PER_CYCLE(2)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(sw_valid), .o_in_ready(rdy2),
      .i_in_data(in_data), .i_in_bypass(in_bypass), .o_out_valid(ov2),
      .i_out_ready(sw_ready), .o_out_data(od2), .o_busy(busy2)
   );
   mix_columns_ctrl #(.COLS_PER_CYCLE(4)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(sw_valid), .o_in_ready(rdy4),
      .i_in_data(in_data), .i_in_bypass(in_bypass), .o_out_valid(ov4),
      .i_out_ready(sw_ready), .o_out_data(od4), .o_busy(busy4)
   );

   // Reference: generic GF(2^8) multiply by a small constant, then the
   // circulant (2 3 1 1) matrix applied byte by byte.
   function automatic logic [7:0] gmul(input logic [7:0] a, input int unsigned k);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 2; i++) begin
         if (k[i]) acc ^= x;
         x = x[7] ? (8'(x << 1) ^ 8'h1B) : 8'(x << 1);
      end
      return acc;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic byp);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [127:0] res;
      int unsigned  coef;
      if (byp) return d;
      for (int k = 0; k < 16; k++) a[k] = d[127-8*k -: 8];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            b[4*c+r] = 8'h00;
            for (int j = 0; j < 4; j++) begin
               case ((j - r) & 3)
                  0:       coef = 2;
                  1:       coef = 3;
                  default: coef = 1;
               endcase
               b[4*c+r] ^= gmul(a[4*c+j], coef);
            end
         end
      end
      res = '0;
      for (int k = 0; k < 16; k++) res[127-8*k -: 8] = b[k];
      return res;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Offers one state on dut1 and returns at the negedge following the accept edge.
   task automatic accept(input logic [127:0] d, input logic b, input string tag);
      int guard;
      @(negedge clk);
      in_data   = d;
      in_bypass = b;
      in_valid  = 1'b1;
      guard     = 0;
      while (!rdy1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_in_ready"}, 128'(rdy1), 128'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_ov1(input string tag);
      int guard;
      guard = 0;
      while (!ov1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_out_valid"}, 128'(ov1), 128'(1));
   endtask

   task automatic do_txn(input logic [127:0] d, input logic b, input logic [127:0] exp,
                         input int exp_lat, input bit rnd_rdy, input string tag);
      int lat, guard, busy_cnt;
      if (!rnd_rdy) out_ready = 1'b1;
      accept(d, b, tag);
      lat      = 1;
      busy_cnt = 0;
      while (!ov1 && lat < 20) begin
         if (busy1) busy_cnt++;
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      check({tag, "_data"}, od1, exp);
      guard = 0;
      while (ov1 && guard < 40) begin
         if (busy1) busy_cnt++;
         if (od1 !== exp)  check({tag, "_hold_data"}, od1, exp);
         if (rdy1 !== 1'b0) check({tag, "_hold_in_ready"}, 128'(rdy1), 128'(0));
         if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         guard++;
      end
      check({tag, "_drained"}, 128'(ov1), 128'(0));
      if (!rnd_rdy) check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(exp_lat));
   endtask

   typedef struct {
      logic [127:0] data;
      logic         bypass;
      logic [127:0] exp;
      int           lat;
   } vec_t;

   initial begin
      vec_t         vecs [5];
      logic [127:0] rnd_d, d2, d4;
      logic         rnd_b, spurious;
      int           cnt, lat2, lat4;

      vecs[0] = '{FIPS_IN, 1'b0, FIPS_OUT, 5};
      vecs[1] = '{FIPS_IN, 1'b1, FIPS_IN, 1};
      vecs[2] = '{C6_IN, 1'b0, C6_IN, 5};
      vecs[3] = '{128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5, 1'b0,
                  128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6, 5};
      vecs[4] = '{128'h0, 1'b0, 128'h0, 5};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0;
      out_ready = 1'b0; sw_valid = 1'b0; sw_ready = 1'b1;

      // Reset state
      in_data = FIPS_IN; in_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 128'(ov1), 128'(0));
      check("rst_in_ready", 128'(rdy1), 128'(0));
      check("rst_busy", 128'(busy1), 128'(0));
      check("rst_out_data", od1, 128'(0));
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1 check("rdy_before_first_edge", 128'(rdy1), 128'(0));
      @(negedge clk);
      check("rdy_after_first_edge", 128'(rdy1), 128'(1));

      for (int i = 0; i < 5; i++) begin
         do_txn(vecs[i].data, vecs[i].bypass, vecs[i].exp, vecs[i].lat, 1'b0,
                $sformatf("vec%0d", i));
      end

      // Backpressure with a second offer held during MIX/DONE
      out_ready = 1'b0;
      accept(FIPS_IN, 1'b0, "bp");
      in_data  = C6_IN;
      in_valid = 1'b1;
      wait_ov1("bp");
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp_hold_data%0d", i), od1, FIPS_OUT);
         check($sformatf("bp_hold_rdy%0d", i), 128'(rdy1), 128'(0));
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 128'(ov1), 128'(0));
      check("bp_release_rdy", 128'(rdy1), 128'(1));
      check("bp_release_busy", 128'(busy1), 128'(0));
      @(negedge clk);
      check("bp_second_accepted", 128'(busy1), 128'(1));
      in_valid = 1'b0;
      wait_ov1("bp2");
      check("bp_second_data", od1, C6_IN);
      @(negedge clk);

      // Reset during the second MIX cycle
      accept(FIPS_IN, 1'b0, "rmix");
      @(negedge clk);
      check("rmix_busy_before", 128'(busy1), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      check("rmix_out_valid", 128'(ov1), 128'(0));
      check("rmix_busy", 128'(busy1), 128'(0));
      check("rmix_out_data", od1, 128'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      spurious = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (ov1) spurious = 1'b1;
      end
      check("rmix_no_spurious", 128'(spurious), 128'(0));
      do_txn(FIPS_IN, 1'b0, FIPS_OUT, 5, 1'b0, "rmix_next");

      // Reset while holding a result in DONE
      out_ready = 1'b0;
      accept(FIPS_IN, 1'b1, "rdone");
      wait_ov1("rdone");
      #2 rst_n = 1'b0;
      #1;
      check("rdone_out_valid", 128'(ov1), 128'(0));
      check("rdone_out_data", od1, 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ov1) spurious = 1'b1;
      end
      check("rdone_no_spurious", 128'(spurious), 128'(0));

      // Parameter sweep: COLS_PER_CYCLE = 2 and 4
      @(negedge clk);
      check("sweep_rdy2", 128'(rdy2), 128'(1));
      check("sweep_rdy4", 128'(rdy4), 128'(1));
      in_data = FIPS_IN; in_bypass = 1'b0; sw_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sw_valid = 1'b0;
      cnt = 1; lat2 = 0; lat4 = 0; d2 = '0; d4 = '0;
      repeat (8) begin
         if (ov2 && lat2 == 0) begin lat2 = cnt; d2 = od2; end
         if (ov4 && lat4 == 0) begin lat4 = cnt; d4 = od4; end
         @(negedge clk);
         cnt++;
      end
      check("sweep2_latency", 128'(lat2), 128'(3));
      check("sweep2_data", d2, FIPS_OUT);
      check("sweep4_latency", 128'(lat4), 128'(2));
      check("sweep4_data", d4, FIPS_OUT);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 30; i++) begin
         rnd_d = {$urandom, $urandom, $urandom, $urandom};
         rnd_b = ($urandom_range(0, 3) == 0);
         do_txn(rnd_d, rnd_b, model(rnd_d, rnd_b), rnd_b ? 1 : 5, 1'b1,
                $sformatf("rnd%0d", i));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
